// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch front end: fetch FSM states, word type and PC arithmetic.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        StRun,
        StHold,
        StHalted
    } fetch_state_t;

    localparam word_t PC_INC = 32'd4;

    // Instruction addresses are always word aligned.
    function automatic word_t word_align(word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-cache request/response bus between the fetch unit (master) and the icache (slave).
interface fetch_unit_if;

    logic                      ihit;
    cpu_types_pkg::word_t      imemload;
    logic                      imemREN;
    cpu_types_pkg::word_t      imemaddr;

    modport master (
        input  ihit,
        input  imemload,
        output imemREN,
        output imemaddr
    );

    modport slave (
        output ihit,
        output imemload,
        input  imemREN,
        input  imemaddr
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC+4 while the pipeline stalls.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load_i,
    input  logic  clear_i,
    input  word_t npc_i,
    input  word_t instr_i,
    output word_t buf_npc_o,
    output word_t buf_instr_o,
    output logic  buf_valid_o
);

    word_t npc_q;
    word_t instr_q;
    logic  valid_q;

    // Clear wins over load so a redirect or halt always discards the entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            npc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            npc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            npc_q   <= npc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign buf_npc_o   = npc_q;
    assign buf_instr_o = instr_q;
    assign buf_valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, icache requests, stall skid buffer, redirect and halt handling.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                nRST,
    fetch_unit_if.master        icache,
    input  logic                stall,
    input  logic                redirect_en,
    input  word_t               redirect_pc,
    input  logic                halt,
    output word_t               npc_o,
    output word_t               instr_o,
    output logic                pipe_en_o,
    output logic                flush_o
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pc_inc;
    logic         buf_load, buf_clear, buf_valid;
    word_t        buf_npc, buf_instr;

    assign pc_inc = pc_q + PC_INC;

    fetch_skid_buf u_skid_buf (
        .CLK         (CLK),
        .nRST        (nRST),
        .load_i      (buf_load),
        .clear_i     (buf_clear),
        .npc_i       (pc_inc),
        .instr_i     (icache.imemload),
        .buf_npc_o   (buf_npc),
        .buf_instr_o (buf_instr),
        .buf_valid_o (buf_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StRun;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (redirect_en) begin
            state_d   = StRun;
            pc_d      = word_align(redirect_pc);
            buf_clear = 1'b1;
        end else if (halt) begin
            state_d   = StHalted;
            buf_clear = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (icache.ihit) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_d  = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        state_d   = StRun;
                        buf_clear = 1'b1;
                    end
                end
                StHalted: ;
                default: state_d = StRun;
            endcase
        end
    end

    // Pipeline-facing outputs are forced to zero while reset is held.
    always_comb begin
        icache.imemREN  = (state_q == StRun);
        icache.imemaddr = pc_q;
        npc_o           = '0;
        instr_o         = '0;
        pipe_en_o       = 1'b0;
        flush_o         = 1'b0;
        if (nRST) begin
            flush_o = redirect_en;
            unique case (state_q)
                StRun: begin
                    npc_o     = pc_inc;
                    instr_o   = icache.imemload;
                    pipe_en_o = icache.ihit && !stall && !redirect_en && !halt;
                end
                StHold: begin
                    npc_o     = buf_npc;
                    instr_o   = buf_instr;
                    pipe_en_o = buf_valid && !stall && !redirect_en && !halt;
                end
                StHalted: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand-written async reset sequences.
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] npc_o;
    logic [31:0] instr_o;
    logic        pipe_en_o;
    logic        flush_o;

    int total = 0;
    int bad   = 0;

    fetch_unit_if ic_if ();

    fetch_unit #(
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .icache      (ic_if),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .npc_o       (npc_o),
        .instr_o     (instr_o),
        .pipe_en_o   (pipe_en_o),
        .flush_o     (flush_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        hlt;
        logic        stl;
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] addr;
        logic        pe;
        logic        fl;
        logic [31:0] npc;
        logic [31:0] instr;
    } vec_t;

    localparam int NumVec = 24;
    vec_t vecs[NumVec];

    function automatic vec_t mk(logic redir, logic [31:0] rpc, logic hlt, logic stl, logic hit,
                                logic [31:0] load, logic ren, logic [31:0] addr, logic pe,
                                logic fl, logic [31:0] npc, logic [31:0] instr);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.hlt = hlt; v.stl = stl; v.hit = hit; v.load = load;
        v.ren = ren; v.addr = addr; v.pe = pe; v.fl = fl; v.npc = npc; v.instr = instr;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic ren, input logic [31:0] addr,
                           input logic pe, input logic fl, input logic [31:0] npc,
                           input logic [31:0] instr);
        chk("imemREN", idx, {31'b0, ic_if.imemREN}, {31'b0, ren});
        chk("imemaddr", idx, ic_if.imemaddr, addr);
        chk("pipe_en_o", idx, {31'b0, pipe_en_o}, {31'b0, pe});
        chk("flush_o", idx, {31'b0, flush_o}, {31'b0, fl});
        chk("npc_o", idx, npc_o, npc);
        chk("instr_o", idx, instr_o, instr);
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic hlt,
                         input logic stl, input logic hit, input logic [31:0] load);
        redirect_en    = redir;
        redirect_pc    = rpc;
        halt           = hlt;
        stall          = stl;
        ic_if.ihit     = hit;
        ic_if.imemload = load;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // redir rpc hlt stl hit load | ren addr pe fl npc instr
        vecs[0]  = mk(0, 0, 0, 0, 1, 32'h11, 1, 32'h0, 1, 0, 32'h4, 32'h11);
        vecs[1]  = mk(0, 0, 0, 0, 1, 32'h22, 1, 32'h4, 1, 0, 32'h8, 32'h22);
        vecs[2]  = mk(0, 0, 0, 0, 1, 32'h33, 1, 32'h8, 1, 0, 32'hC, 32'h33);
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'hC, 0, 0, 32'h10, 32'h0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'hC, 0, 0, 32'h10, 32'h0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'hC, 0, 0, 32'h10, 32'h0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 32'h2001_0005, 1, 32'hC, 1, 0, 32'h10, 32'h2001_0005);
        vecs[7]  = mk(0, 0, 0, 1, 1, 32'hAAAA_0001, 1, 32'h10, 0, 0, 32'h14, 32'hAAAA_0001);
        vecs[8]  = mk(0, 0, 0, 1, 1, 32'hDEAD, 0, 32'h14, 0, 0, 32'h14, 32'hAAAA_0001);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h14, 1, 0, 32'h14, 32'hAAAA_0001);
        vecs[10] = mk(0, 0, 0, 0, 1, 32'h55, 1, 32'h14, 1, 0, 32'h18, 32'h55);
        vecs[11] = mk(0, 0, 0, 1, 1, 32'h66, 1, 32'h18, 0, 0, 32'h1C, 32'h66);
        vecs[12] = mk(1, 32'h103, 0, 1, 0, 32'h0, 0, 32'h1C, 0, 1, 32'h1C, 32'h66);
        vecs[13] = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h100, 0, 0, 32'h104, 32'h0);
        vecs[14] = mk(1, 32'h200, 1, 0, 1, 32'h77, 1, 32'h100, 0, 1, 32'h104, 32'h77);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h200, 0, 0, 32'h204, 32'h0);
        vecs[16] = mk(0, 0, 1, 0, 1, 32'h88, 1, 32'h200, 0, 0, 32'h204, 32'h88);
        vecs[17] = mk(0, 0, 0, 0, 1, 32'h99, 0, 32'h200, 0, 0, 32'h0, 32'h0);
        vecs[18] = mk(0, 0, 0, 0, 1, 32'h99, 0, 32'h200, 0, 0, 32'h0, 32'h0);
        vecs[19] = mk(1, 32'h40, 0, 0, 0, 32'h0, 0, 32'h200, 0, 1, 32'h0, 32'h0);
        vecs[20] = mk(0, 0, 0, 0, 1, 32'hAB, 1, 32'h40, 1, 0, 32'h44, 32'hAB);
        vecs[21] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 1, 32'h44, 0, 1, 32'h48, 32'h0);
        vecs[22] = mk(0, 0, 0, 0, 1, 32'hCD, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'hCD);
        vecs[23] = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 0, 32'h4, 32'h0);

        nRST = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h1234_5678);
        #2;
        chk_all(100, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        chk_all(101, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        nRST = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].hlt, vecs[i].stl, vecs[i].hit,
                  vecs[i].load);
            #2;
            chk_all(i, vecs[i].ren, vecs[i].addr, vecs[i].pe, vecs[i].fl, vecs[i].npc,
                    vecs[i].instr);
            next_cycle();
        end

        // Async reset in the middle of a miss at 0x80.
        drive(1, 32'h80, 0, 0, 0, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 32'h5A5A);
        #2;
        chk_all(200, 1, 32'h80, 0, 0, 32'h84, 32'h5A5A);
        #2;
        nRST = 1'b0;
        #1;
        chk_all(201, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        next_cycle();
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk_all(202, 1, 32'h0, 0, 0, 32'h4, 32'h0);

        // Async reset while holding a buffered instruction.
        next_cycle();
        drive(0, 0, 0, 1, 1, 32'h77);
        #2;
        chk_all(300, 1, 32'h0, 0, 0, 32'h4, 32'h77);
        next_cycle();
        drive(0, 0, 0, 1, 0, 32'h0);
        #2;
        chk_all(301, 0, 32'h4, 0, 0, 32'h4, 32'h77);
        #2;
        nRST = 1'b0;
        #1;
        chk_all(302, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        next_cycle();
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk_all(303, 1, 32'h0, 0, 0, 32'h4, 32'h0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
